// File: rtl/adder5_accum_sched.sv
// Sequencer that sums up to p_max_terms unsigned terms by time-sharing one 5-input adder
// over groups of five fetched from an external memory. The accumulator saturates.

module adder_5in #(
    parameter int unsigned p_width = 16
) (
    input  logic [5*p_width-1:0] terms,
    output logic [p_width+2:0]   sum
);

    always_comb begin
        sum = '0;
        for (int k = 0; k < 5; k++) begin
            sum = sum + (p_width + 3)'(terms[k*p_width +: p_width]);
        end
    end

endmodule

module adder5_accum_sched #(
    parameter int unsigned p_width     = 16,
    parameter int unsigned p_max_terms = 64,
    parameter int unsigned p_cnt_w     = 7,
    parameter int unsigned p_acc_w     = 24,
    parameter int unsigned p_addr_w    = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [p_cnt_w-1:0]     i_num_terms,
    output logic                   o_busy,
    output logic                   o_rd_en,
    output logic [p_addr_w-1:0]    o_rd_addr,
    input  logic [5*p_width-1:0]   i_rd_data,
    input  logic                   i_rd_valid,
    output logic [p_acc_w-1:0]     o_sum,
    output logic                   o_sat,
    output logic                   o_valid,
    input  logic                   i_ready
);

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StAcc, StDone} state_e;

    localparam int unsigned SumW = p_width + 3;
    localparam logic [p_cnt_w-1:0] MaxTerms = p_cnt_w'(p_max_terms);
    localparam logic [p_cnt_w-1:0] Five     = p_cnt_w'(5);

    state_e                 state_q, state_d;
    logic [p_acc_w-1:0]     acc_q, acc_d;
    logic                   sat_q, sat_d;
    logic [p_cnt_w-1:0]     rem_q, rem_d;
    logic [p_addr_w-1:0]    group_q, group_d;
    logic [5*p_width-1:0]   lanes_q, lanes_d;

    logic [p_cnt_w-1:0]     n_eff;
    logic [SumW-1:0]        add_sum;
    logic [p_acc_w:0]       acc_sum;

    adder_5in #(
        .p_width (p_width)
    ) u_adder (
        .terms (lanes_q),
        .sum   (add_sum)
    );

    always_comb begin
        n_eff   = (i_num_terms > MaxTerms) ? MaxTerms : i_num_terms;
        // One spare bit above the accumulator catches overflow for saturation.
        acc_sum = {1'b0, acc_q} + {{(p_acc_w + 1 - SumW){1'b0}}, add_sum};
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        rem_d   = rem_q;
        group_d = group_q;
        lanes_d = lanes_q;

        case (state_q)
            StIdle: begin
                if (i_start) begin
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    group_d = '0;
                    rem_d   = n_eff;
                    state_d = (n_eff == '0) ? StDone : StFetch;
                end
            end
            StFetch: state_d = StWait;
            StWait: begin
                if (i_rd_valid) begin
                    lanes_d = i_rd_data;
                    // Lanes beyond the remaining term count belong to no term of this job.
                    for (int k = 0; k < 5; k++) begin
                        if (p_cnt_w'(k) >= rem_q) begin
                            lanes_d[k*p_width +: p_width] = '0;
                        end
                    end
                    state_d = StAcc;
                end
            end
            StAcc: begin
                if (sat_q || acc_sum[p_acc_w]) begin
                    acc_d = '1;
                    sat_d = 1'b1;
                end else begin
                    acc_d = acc_sum[p_acc_w-1:0];
                end
                rem_d   = (rem_q > Five) ? (rem_q - Five) : '0;
                group_d = group_q + p_addr_w'(1);
                state_d = (rem_q <= Five) ? StDone : StFetch;
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            rem_q   <= '0;
            group_q <= '0;
            lanes_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            rem_q   <= rem_d;
            group_q <= group_d;
            lanes_q <= lanes_d;
        end
    end

    assign o_busy    = (state_q != StIdle);
    assign o_rd_en   = (state_q == StFetch);
    assign o_rd_addr = group_q;
    assign o_valid   = (state_q == StDone);
    assign o_sum     = acc_q;
    assign o_sat     = sat_q;

endmodule

// File: doc/adder5_accum_sched.md
Name: adder5_accum_sched

Overview:
- Sequencer that time-shares one adder_5in instance (5-operand unsigned adder, result width p_width+3) to sum N unsigned terms.
- Terms are fetched from an external packed-weight/spike-count memory in groups of 5 and accumulated into a saturating accumulator.
- Used by the SNN neuron stage to form membrane-potential sums before threshold compare.
- The result is returned through a valid/ready handshake.

Parameters:
- p_width, 16: width of each term, and of each adder_5in operand.
- p_max_terms, 64: maximum terms per job; larger requests are clamped to this value.
- p_cnt_w, 7: width of i_num_terms; must satisfy 2^p_cnt_w > p_max_terms.
- p_acc_w, 24: accumulator/result width; must be at least p_width+3.
- p_addr_w, 4: group-address width; must satisfy 2^p_addr_w ≥ ceil(p_max_terms/5).

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  job request pulse; sampled only in IDLE.
- i_num_terms  in  p_cnt_w  number of terms N for the job; captured with i_start.
- o_busy  out  1  high in every state except IDLE.
- o_rd_en  out  1  group read request; one-cycle pulse.
- o_rd_addr  out  p_addr_w  group index, 0..G-1.
- i_rd_data  in  5*p_width  five terms; lane k = bits [(k+1)*p_width-1 : k*p_width].
- i_rd_valid  in  1  read data valid; arrives 1 or more cycles after o_rd_en.
- o_sum  out  p_acc_w  final sum, stable while o_valid is high.
- o_sat  out  1  saturation occurred during the job; qualified by o_valid.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: state=IDLE; o_busy, o_rd_en, o_valid, o_sat = 0; o_sum = 0; o_rd_addr = 0; internal accumulator and counters = 0.
- Reset mid-job aborts immediately. Any i_rd_valid after reset release is ignored, because it is only honoured in WAIT.
- Job setup:
  - Neff = min(i_num_terms, p_max_terms).
  - G = ceil(Neff/5).
  - rem = Neff, decremented by 5 per group, floored at 0.
- States and transitions:
  - IDLE:
    - i_start=1 and Neff=0: clear accumulator and sat → DONE. No reads are issued; the result is 0.
    - i_start=1 and Neff>0: clear accumulator and sat, group=0, load rem → FETCH.
    - i_start while not in IDLE is ignored. It is not queued.
  - FETCH: o_rd_en=1 for exactly one cycle with o_rd_addr=group → WAIT.
  - WAIT:
    - Hold until i_rd_valid=1.
    - On that cycle, lanes k ≥ rem are forced to 0 before they reach the adder. Only the last group can be partial.
    - Register the masked lanes → ACC.
  - ACC: add one cycle.
    - s = adder_5in(masked lanes), zero-extended to p_acc_w+1 bits.
    - t = acc + s.
    - If t ≥ 2^p_acc_w: acc = all-ones and sat=1; otherwise acc = t.
    - Once saturated, acc stays all-ones for the rest of the job.
    - rem = rem-5, floored at 0; group++.
    - If group was G-1 → DONE; otherwise → FETCH.
  - DONE:
    - o_valid=1, o_sum=acc, o_sat=sat.
    - Hold until i_ready=1. On that cycle → IDLE; o_valid drops on the next edge.
    - i_start in the DONE/ready cycle is ignored.
    - i_ready outside DONE has no effect.
- Latency:
  - With read latency L, each group takes 2+L cycles (FETCH, L-cycle WAIT, ACC).
  - o_valid rises G*(2+L) cycles after the start edge.
  - For Neff=0, o_valid rises 1 cycle after the start edge.
- Arithmetic: all values are unsigned.
  - Per-group maximum is 5*(2^p_width-1), which fits in p_width+3 bits.
  - The adder output is never truncated.
- Read handshake: one outstanding read at most. o_rd_addr holds its value from FETCH through WAIT.

Test Plan:
- Directed N=5, all lanes 16'h0001, read latency 1, i_ready=1 → one read at addr 0; o_sum=5, o_sat=0; o_valid high 3 cycles after start.
- Directed N=12, groups {10,20,30,40,50}, {1,2,3,4,5}, {7,7,99,99,99}, latency 2 → 3 reads at addr 0,1,2; lanes 2–4 of group 2 masked; o_sum=150+15+14=179; o_valid 12 cycles after start.
- Directed N=0 → no o_rd_en; o_sum=0; o_valid 1 cycle after start. Then i_num_terms=100 → clamped to 64; 13 reads, last addr 12.
- Directed saturation: p_acc_w=20, N=64, all lanes 16'hFFFF:
  - True total is 64*65535 = 4194240 > 2^20-1.
  - Required: o_sum=20'hFFFFF, o_sat=1.
  - A following job with N=1, value 3 must give o_sum=3, o_sat=0.
- Directed backpressure and ignored start: hold i_ready=0 for 10 cycles in DONE; pulse i_start during WAIT and during DONE.
  - Required: o_valid and o_sum stable throughout; no extra job starts; after the ready cycle, o_busy=0.
- Directed reset mid-job: assert i_rst_n=0 during WAIT of group 1, and drive i_rd_valid after release.
  - Required: all outputs 0 immediately; state IDLE; the stray i_rd_valid is ignored; the next job returns the correct sum.
